subservient_dbg_loader: RTL and testbench
=========================================

Name: subservient_dbg_loader

Overview:
- Wishbone initiator for the subservient debug port (i_debug_mode, i_wb_dbg_*).
- Accepts a firmware byte stream from the outside world, packs it little-endian into 32-bit words and writes them into SRAM through the debug bus.
- Holds the core in debug mode for the duration of the load, then releases it so the CPU boots from address 0.
- Sits beside subservient in FPGA tops and sim benches, replacing $readmemh preload.

Parameters:
- memsize, 512, SRAM size in bytes; capacity limit for the load.
- aw, $clog2(memsize), byte address width.
- ACK_TIMEOUT, 255, maximum cycles stb may wait for ack before error; counter width 8 bits.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  begin load; sampled in IDLE or DONE only
- i_byte_data  in  8  firmware byte
- i_byte_valid  in  1  byte present
- i_byte_last  in  1  qualifies final byte of image
- o_byte_ready  out  1  byte accepted when valid&ready
- o_debug_mode  out  1  to subservient i_debug_mode
- o_wb_dbg_adr  out  32  byte address, word aligned
- o_wb_dbg_dat  out  32  write data
- o_wb_dbg_sel  out  4  byte lanes
- o_wb_dbg_we  out  1  write enable
- o_wb_dbg_stb  out  1  strobe
- i_wb_dbg_rdt  in  32  read data (used only with verify)
- i_wb_dbg_ack  in  1  ack
- o_busy  out  1  high in any state other than IDLE/DONE
- o_done  out  1  level; high in DONE until next i_start or reset
- o_err  out  1  level; sticky until next i_start or reset
- o_count  out  aw+1  bytes accepted this load

Behaviour:
- Reset: all outputs 0; state IDLE; address, lane, sel and count cleared. Reset mid-transfer drops stb and debug_mode the following cycle with no completion.
- States:
  - IDLE / DONE: on i_start, go to COLLECT. Entry sets debug_mode=1, adr=0, lane=0, sel=0, count=0, done=0, err=0.
  - COLLECT: o_byte_ready=1.
    - On valid&ready: byte goes to dat[8*lane+7:8*lane] and sel[lane]=1; count+1; lane+1 (mod 4).
    - If lane was 3 or i_byte_last=1: go to WRITE; remember last.
    - If count==memsize when a byte is accepted: byte is consumed but not stored; err=1; go to DONE.
  - WRITE: stb=1, we=1, adr/dat/sel stable; o_byte_ready=0; timeout counter runs.
    - On ack: adr+=4, dat=0, sel=0, lane=0. Then go to DONE if last was set, else COLLECT (VERIFY when enabled).
    - stb is low the cycle after ack.
  - DONE: debug_mode=0, stb=0, done=1, err held.
- Ack is ignored while stb=0.
- Timeout: counter reaches ACK_TIMEOUT with no ack: err=1, stb dropped, go to DONE.
- Partial last word: only written lanes set in sel; unwritten lanes of dat are 0.
- i_start while busy: ignored.
- i_byte_last on a byte rejected for overflow: still ends in DONE with err.
- Empty image: not possible; at least one byte is required.

Optional Feature:
- Macro: SUBSERVIENT_LOADER_VERIFY_EN.
- Defined: after each write ack, go to VERIFY.
  - Issue a read to the same adr (stb=1, we=0, sel as written); same timeout rule applies.
  - On ack, compare i_wb_dbg_rdt against written data on sel lanes only.
  - Mismatch: err=1, go to DONE. Match: continue as for a write ack (COLLECT or DONE).
- Not defined: no read cycles; we=1 whenever stb=1; i_wb_dbg_rdt unused.

Test Plan:
- Four bytes 11,22,33,44 (last on 44), ack after 1 cycle -> one write: adr 0, dat 0x44332211, sel 1111. Then done=1, debug_mode=0, o_count=4, err=0.
- Five bytes 11..55 -> writes at adr 0 (sel 1111) and adr 4 (dat 0x00000055, sel 0001). o_byte_ready=0 throughout each WRITE.
- Ack delayed 3 cycles -> stb/adr/dat/sel held stable for 4 cycles, stb=0 on the next cycle, no extra write.
- memsize=8, 9 bytes streamed -> two writes, 9th byte consumed, err=1, done=1, o_count=8.
- Ack never returned -> err=1 and stb=0 after 255 stb cycles; debug_mode=0.
- Reset asserted during WRITE -> next cycle stb=0, debug_mode=0, busy=0; new i_start reloads from adr 0.
- Verify build, slave returns 0x44332210 -> err=1 after the read.

Source files
------------

// File: rtl/subservient_dbg_loader.sv
`default_nettype none
// ============================================================================
// Module   : subservient_dbg_loader
// Brief    : Packs a firmware byte stream little-endian into 32-bit words and
//            writes them to SRAM over the subservient debug Wishbone port while
//            holding the core in debug mode. Optional readback check of every
//            word when SUBSERVIENT_LOADER_VERIFY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module subservient_dbg_loader #(
    parameter int memsize     = 512,
    parameter int aw          = $clog2(memsize),
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_byte_data,
    input  logic          i_byte_valid,
    input  logic          i_byte_last,
    output logic          o_byte_ready,
    output logic          o_debug_mode,
    output logic [31:0]   o_wb_dbg_adr,
    output logic [31:0]   o_wb_dbg_dat,
    output logic [3:0]    o_wb_dbg_sel,
    output logic          o_wb_dbg_we,
    output logic          o_wb_dbg_stb,
    input  logic [31:0]   i_wb_dbg_rdt,
    input  logic          i_wb_dbg_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [aw:0]   o_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_VERIFY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [aw:0] c_mem_bytes = (aw+1)'(memsize);
    localparam logic [aw:0] c_count_one = (aw+1)'(1);
    localparam logic [7:0]  c_tmo_last  = 8'(ACK_TIMEOUT - 1);

    state_t      r_state_q, w_state_d;
    logic [31:0] r_adr_q,   w_adr_d;
    logic [31:0] r_dat_q,   w_dat_d;
    logic [3:0]  r_sel_q,   w_sel_d;
    logic [1:0]  r_lane_q,  w_lane_d;
    logic [aw:0] r_count_q, w_count_d;
    logic        r_last_q,  w_last_d;
    logic        r_err_q,   w_err_d;
    logic [7:0]  r_tmo_q,   w_tmo_d;
    logic        w_advance;
    logic        w_rd_mismatch;

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
    logic [31:0] w_lane_mask;
    for (genvar g = 0; g < 4; g++) begin : g_lane_mask
        assign w_lane_mask[8*g +: 8] = {8{r_sel_q[g]}};
    end
    assign w_rd_mismatch = |((i_wb_dbg_rdt ^ r_dat_q) & w_lane_mask);
`else
    logic w_unused_rdt;
    assign w_unused_rdt  = ^i_wb_dbg_rdt;
    assign w_rd_mismatch = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_adr_d   = r_adr_q;
        w_dat_d   = r_dat_q;
        w_sel_d   = r_sel_q;
        w_lane_d  = r_lane_q;
        w_count_d = r_count_q;
        w_last_d  = r_last_q;
        w_err_d   = r_err_q;
        w_tmo_d   = r_tmo_q;
        w_advance = 1'b0;

        case (r_state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_d = S_COLLECT;
                    w_adr_d   = '0;
                    w_dat_d   = '0;
                    w_sel_d   = '0;
                    w_lane_d  = '0;
                    w_count_d = '0;
                    w_last_d  = 1'b0;
                    w_err_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                if (i_byte_valid) begin
                    // Overflow byte is swallowed so the source is never stalled.
                    if (r_count_q == c_mem_bytes) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_DONE;
                    end else begin
                        w_dat_d[{r_lane_q, 3'b000} +: 8] = i_byte_data;
                        w_sel_d[r_lane_q] = 1'b1;
                        w_count_d = r_count_q + c_count_one;
                        w_lane_d  = r_lane_q + 2'd1;
                        if (r_lane_q == 2'd3 || i_byte_last) begin
                            w_state_d = S_WRITE;
                            w_last_d  = i_byte_last;
                            w_tmo_d   = '0;
                        end
                    end
                end
            end
            S_WRITE, S_VERIFY: begin
                if (i_wb_dbg_ack) begin
`ifdef SUBSERVIENT_LOADER_VERIFY_EN
                    if (r_state_q == S_WRITE) begin
                        w_state_d = S_VERIFY;
                        w_tmo_d   = '0;
                    end else if (w_rd_mismatch) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
`else
                    w_advance = 1'b1;
`endif
                end else if (r_tmo_q == c_tmo_last) begin
                    w_err_d   = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_tmo_d = r_tmo_q + 8'd1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_advance) begin
            w_adr_d   = r_adr_q + 32'd4;
            w_dat_d   = '0;
            w_sel_d   = '0;
            w_lane_d  = '0;
            w_state_d = r_last_q ? S_DONE : S_COLLECT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= S_IDLE;
            r_adr_q   <= '0;
            r_dat_q   <= '0;
            r_sel_q   <= '0;
            r_lane_q  <= '0;
            r_count_q <= '0;
            r_last_q  <= 1'b0;
            r_err_q   <= 1'b0;
            r_tmo_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_adr_q   <= w_adr_d;
            r_dat_q   <= w_dat_d;
            r_sel_q   <= w_sel_d;
            r_lane_q  <= w_lane_d;
            r_count_q <= w_count_d;
            r_last_q  <= w_last_d;
            r_err_q   <= w_err_d;
            r_tmo_q   <= w_tmo_d;
        end
    end

    assign o_busy       = (r_state_q == S_COLLECT) || (r_state_q == S_WRITE) ||
                          (r_state_q == S_VERIFY);
    assign o_debug_mode = o_busy;
    assign o_byte_ready = (r_state_q == S_COLLECT);
    assign o_wb_dbg_stb = (r_state_q == S_WRITE) || (r_state_q == S_VERIFY);
    assign o_wb_dbg_we  = (r_state_q == S_WRITE);
    assign o_wb_dbg_adr = r_adr_q;
    assign o_wb_dbg_dat = r_dat_q;
    assign o_wb_dbg_sel = r_sel_q;
    assign o_done       = (r_state_q == S_DONE);
    assign o_err        = r_err_q;
    assign o_count      = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_subservient_dbg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_subservient_dbg_loader
// Brief    : Directed self-checking bench for subservient_dbg_loader with a
//            Wishbone slave model of programmable ack latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subservient_dbg_loader;

    localparam int c_memsize = 8;
    localparam int c_aw      = $clog2(c_memsize);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      byte_data = 8'd0;
    logic            byte_valid = 1'b0;
    logic            byte_last = 1'b0;
    logic            byte_ready;
    logic            debug_mode;
    logic [31:0]     adr;
    logic [31:0]     dat;
    logic [3:0]      sel;
    logic            we;
    logic            stb;
    logic [31:0]     rdt;
    logic            ack = 1'b0;
    logic            busy;
    logic            done;
    logic            err;
    logic [c_aw:0]   count;

    always #5 clk = ~clk;

    subservient_dbg_loader #(
        .memsize     (c_memsize),
        .ACK_TIMEOUT (255)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_byte_data  (byte_data),
        .i_byte_valid (byte_valid),
        .i_byte_last  (byte_last),
        .o_byte_ready (byte_ready),
        .o_debug_mode (debug_mode),
        .o_wb_dbg_adr (adr),
        .o_wb_dbg_dat (dat),
        .o_wb_dbg_sel (sel),
        .o_wb_dbg_we  (we),
        .o_wb_dbg_stb (stb),
        .i_wb_dbg_rdt (rdt),
        .i_wb_dbg_ack (ack),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_count      (count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave model and bus monitor; all bookkeeping lives in this one process.
    int          ack_delay = 1;
    bit          ack_en = 1'b1;
    bit          corrupt = 1'b0;
    int          clr_gen = 0;
    int          seen_gen = 0;
    int          wait_cnt = 0;
    int          run_cur = 0;
    int          run_last = 0;
    int          run_max = 0;
    bit          unstable = 1'b0;
    bit          rdy_viol = 1'b0;
    logic        prev_stb = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    logic [3:0]  prev_sel = '0;
    logic [31:0] mem [8] = '{default: 32'd0};
    logic [31:0] wr_adr [$];
    logic [31:0] wr_dat [$];
    logic [3:0]  wr_sel [$];

    assign rdt = mem[adr[4:2]] ^ {31'd0, corrupt};

    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            run_last = 0;
            run_max  = 0;
            unstable = 1'b0;
            rdy_viol = 1'b0;
            wr_adr.delete();
            wr_dat.delete();
            wr_sel.delete();
        end
        if (stb) begin
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
            if (prev_stb && (adr !== prev_adr || dat !== prev_dat || sel !== prev_sel))
                unstable = 1'b1;
            if (byte_ready) rdy_viol = 1'b1;
            if (ack_en && wait_cnt == ack_delay) begin
                ack = 1'b1;
                wait_cnt = 0;
                if (we) begin
                    wr_adr.push_back(adr);
                    wr_dat.push_back(dat);
                    wr_sel.push_back(sel);
                    mem[adr[4:2]] = dat;
                end
            end else begin
                ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            if (run_cur != 0) run_last = run_cur;
            run_cur  = 0;
            ack      = 1'b0;
            wait_cnt = 0;
        end
        prev_stb = stb;
        prev_adr = adr;
        prev_dat = dat;
        prev_sel = sel;
    end

    task automatic clear_stats();
        clr_gen++;
        @(negedge clk);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        byte_data  = d;
        byte_last  = l;
        byte_valid = 1'b1;
        while (!byte_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check_val("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_done", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_flags", {25'd0, busy, done, err, debug_mode, stb, byte_ready, we}, 32'd0);
        check_val("rst_count", {28'd0, count}, 32'd0);
        check_val("rst_adr", adr, 32'd0);
        check_val("rst_sel", {28'd0, sel}, 32'd0);

        // Single full word, ack one cycle after stb; stray i_start mid-load.
        clear_stats();
        ack_delay = 1;
        start_load();
        check_val("t1_debug", {31'd0, debug_mode}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        start_load();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done(100);
        check_val("t1_nwr", wr_adr.size(), 32'd1);
        check_val("t1_adr", wr_adr[0], 32'h0);
        check_val("t1_dat", wr_dat[0], 32'h44332211);
        check_val("t1_sel", {28'd0, wr_sel[0]}, 32'hf);
        check_val("t1_debug_end", {31'd0, debug_mode}, 32'd0);
        check_val("t1_count", {28'd0, count}, 32'd4);
        check_val("t1_err", {31'd0, err}, 32'd0);

        // Five bytes: full word then partial word in lane 0.
        clear_stats();
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b1);
        wait_done(100);
        check_val("t2_nwr", wr_adr.size(), 32'd2);
        check_val("t2_dat0", wr_dat[0], 32'h44332211);
        check_val("t2_adr1", wr_adr[1], 32'h4);
        check_val("t2_dat1", wr_dat[1], 32'h00000055);
        check_val("t2_sel1", {28'd0, wr_sel[1]}, 32'h1);
        check_val("t2_ready_in_write", {31'd0, rdy_viol}, 32'd0);
        check_val("t2_count", {28'd0, count}, 32'd5);

        // Ack three cycles late: bus held for four cycles.
        clear_stats();
        ack_delay = 3;
        start_load();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        wait_done(100);
        check_val("t3_nwr", wr_adr.size(), 32'd1);
        check_val("t3_dat", wr_dat[0], 32'hDDCCBBAA);
        check_val("t3_stb_len", run_max, 32'd4);
        check_val("t3_stable", {31'd0, unstable}, 32'd0);
        check_val("t3_stb_end", {31'd0, stb}, 32'd0);

        // Overflow: 9 bytes into an 8-byte memory.
        clear_stats();
        ack_delay = 0;
        start_load();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), i == 9);
        wait_done(100);
        check_val("t4_nwr", wr_adr.size(), 32'd2);
        check_val("t4_dat1", wr_dat[1], 32'h08070605);
        check_val("t4_err", {31'd0, err}, 32'd1);
        check_val("t4_count", {28'd0, count}, 32'd8);

        // No ack at all: timeout after 255 strobe cycles.
        clear_stats();
        ack_en = 1'b0;
        start_load();
        send_byte(8'h5A, 1'b1);
        wait_done(600);
        check_val("t5_err", {31'd0, err}, 32'd1);
        check_val("t5_stb", {31'd0, stb}, 32'd0);
        check_val("t5_debug", {31'd0, debug_mode}, 32'd0);
        check_val("t5_stb_len", run_last, 32'd255);

        // Reset during WRITE, then reload from address 0.
        clear_stats();
        start_load();
        check_val("t6_err_cleared", {31'd0, err}, 32'd0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        check_val("t6_in_write", {31'd0, stb}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_flags", {29'd0, stb, debug_mode, busy}, 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        ack_delay = 0;
        clear_stats();
        start_load();
        send_byte(8'h77, 1'b1);
        wait_done(100);
        check_val("t6_nwr", wr_adr.size(), 32'd1);
        check_val("t6_adr", wr_adr[0], 32'h0);
        check_val("t6_dat", wr_dat[0], 32'h00000077);
        check_val("t6_sel", {28'd0, wr_sel[0]}, 32'h1);

`ifdef SUBSERVIENT_LOADER_VERIFY_EN
        // Readback returns 0x44332210 for a written 0x44332211.
        clear_stats();
        corrupt = 1'b1;
        ack_delay = 1;
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done(100);
        check_val("t7_nwr", wr_adr.size(), 32'd1);
        check_val("t7_err", {31'd0, err}, 32'd1);
        corrupt = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
